// File: rtl/display_scan_if.sv
// rtl/display_scan_if.sv - control and output bundle of the 7-segment scan sequencer
interface display_scan_if;
  logic        en;
  logic [31:0] data;
  logic [7:0]  digit_mask;
  logic [2:0]  bright;
  logic [7:0]  anode;
  logic [2:0]  seg_sel;
  logic [3:0]  nibble;
  logic        frame_done;

  modport master (
    output en, data, digit_mask, bright,
    input  anode, seg_sel, nibble, frame_done
  );

  modport slave (
    input  en, data, digit_mask, bright,
    output anode, seg_sel, nibble, frame_done
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 8-digit 7-segment scan sequencer with mask, PWM and frame latch
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scan_ctrl #(
  parameter int TICK_DIV   = 100000,
  parameter int NUM_DIGITS = 8
) (
  input logic           clk,
  input logic           reset,
  display_scan_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] LAST   = PW'(TICK_DIV - 1);
  localparam logic [PW:0]   EIGHTH = (PW+1)'(TICK_DIV / 8);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t         state;
  logic [IW-1:0]  index;
  logic [PW-1:0]  prescaler;
  logic [31:0]    shadow;
  logic [2:0]     bright_q;
  logic           wrap_pend;
  logic [7:0]     blank;
  logic [PW:0]    on_limit;
  logic           tick;
  logic           lit;

  logic [7:0]     anode_q;
  logic [2:0]     seg_sel_q;
  logic [3:0]     nibble_q;
  logic           frame_done_q;

`ifdef LEADING_ZERO_BLANK_EN
  // Blank every digit above the highest nonzero nibble; digit 0 always shows.
  function automatic logic [7:0] lead_blank(input logic [31:0] d);
    logic [7:0] b;
    logic       seen;
    b    = '0;
    seen = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      seen = seen | (d[4*i +: 4] != 4'h0);
      b[i] = ~seen;
    end
    return b;
  endfunction

  // shadow only changes at frame loads, so deriving blank from it matches a load-time capture
  assign blank = lead_blank(shadow);
`else
  assign blank = '0;
`endif

  assign tick     = (prescaler == LAST);
  assign on_limit = EIGHTH * ((PW+1)'(bright_q) + (PW+1)'(1));
  assign lit      = (state == SCAN) & bus.digit_mask[index] & ~blank[index]
                    & ({1'b0, prescaler} < on_limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      index        <= '0;
      prescaler    <= '0;
      shadow       <= '0;
      bright_q     <= '0;
      wrap_pend    <= 1'b0;
      anode_q      <= 8'hFF;
      seg_sel_q    <= 3'd0;
      nibble_q     <= 4'd0;
      frame_done_q <= 1'b0;
    end else begin
      anode_q      <= ~(8'(lit) << index);
      seg_sel_q    <= index;
      nibble_q     <= shadow[4*index +: 4];
      frame_done_q <= wrap_pend;
      wrap_pend    <= 1'b0;
      case (state)
        IDLE: begin
          index     <= '0;
          prescaler <= '0;
          if (bus.en) begin
            shadow   <= bus.data;
            bright_q <= bus.bright;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (!bus.en) begin
            state     <= IDLE;
            index     <= '0;
            prescaler <= '0;
          end else if (tick) begin
            prescaler <= '0;
            index     <= index - IW'(1);
            bright_q  <= bus.bright;
            // stepping 1->0 starts a frame; the pulse lines up with digit 0's first output cycle
            if (index == IW'(1)) begin
              shadow    <= bus.data;
              wrap_pend <= 1'b1;
            end
          end else begin
            prescaler <= prescaler + PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.anode      = anode_q;
  assign bus.seg_sel    = seg_sel_q;
  assign bus.nibble     = nibble_q;
  assign bus.frame_done = frame_done_q;

endmodule
